// File: rtl/mem_stage.sv
// MEM pipeline stage: holds one instruction, waits for its data_sram response, extends load data for WB.
// Latency: 1 cycle for non-memory ops; memory ops leave in the cycle their data_ok is accepted.
// Backpressure: ws_allowin low stalls the stage, early load data is buffered; MS_LOAD_FWD_EN clears load_pending on data_ok.
module mem_stage (
    input  logic         clk,
    input  logic         resetn,
    input  logic         ws_allowin,
    output logic         ms_allowin,
    input  logic         es_to_ms_valid,
    input  logic [169:0] es_to_ms_bus,
    input  logic         es_mem_req,
    input  logic         data_sram_data_ok,
    input  logic [31:0]  data_sram_rdata,
    input  logic         final_ex,
    input  logic         back_ertn_flush,
    output logic         ms_to_ws_valid,
    output logic [159:0] ms_to_ws_bus,
    output logic [39:0]  ms_forward,
    output logic         ms_ex,
    output logic         ms_ertn_flush
);

    typedef struct packed {
        logic [89:0] ex_info;
        logic [1:0]  addr_lo;
        logic [6:0]  mem_op;   // ld_w, ld_b, ld_bu, ld_h, ld_hu, st_b, st_h
        logic        res_from_mem;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] result;
        logic [31:0] pc;
    } es_bus_t;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} ms_state_e;

    es_bus_t     ms_bus;
    ms_state_e   state;
    logic        ms_valid;
    logic        ms_mem_req;
    logic [1:0]  cancel_cnt;
    logic [31:0] data_buf;

    logic        flush;
    logic        data_ok_acc;
    logic        ms_ready_go;
    logic        load_pending;
    logic [2:0]  cnt_sum;
    logic [1:0]  cnt_next;
    logic [31:0] ld_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] mem_res;
    logic [31:0] final_result;

    assign flush       = final_ex | back_ertn_flush;
    // Responses owed to flushed instructions are swallowed before any new one is accepted.
    assign data_ok_acc = data_sram_data_ok & (cancel_cnt == 2'd0);
    assign ms_ready_go = !ms_mem_req | (state == S_DONE) | ((state == S_WAIT) & data_ok_acc);
    assign ms_allowin  = !ms_valid | (ms_ready_go & ws_allowin);
    assign ms_to_ws_valid = ms_valid & ms_ready_go & ~final_ex;

    always_comb begin
        cnt_sum = {1'b0, cancel_cnt};
        if (flush) begin
            cnt_sum = cnt_sum + 3'(ms_valid & (state == S_WAIT) & ~data_ok_acc) + 3'(es_mem_req);
        end
        if (data_sram_data_ok && cancel_cnt != 2'd0) begin
            cnt_sum = cnt_sum - 3'd1;
        end
        cnt_next = (cnt_sum > 3'd2) ? 2'd2 : cnt_sum[1:0];
    end

    assign ld_data = (state == S_DONE) ? data_buf : data_sram_rdata;
    assign ld_half = ms_bus.addr_lo[1] ? ld_data[31:16] : ld_data[15:0];

    always_comb begin
        case (ms_bus.addr_lo)
            2'd0:    ld_byte = ld_data[7:0];
            2'd1:    ld_byte = ld_data[15:8];
            2'd2:    ld_byte = ld_data[23:16];
            default: ld_byte = ld_data[31:24];
        endcase
    end

    always_comb begin
        case (ms_bus.mem_op)
            7'b0100000: mem_res = {{24{ld_byte[7]}}, ld_byte};
            7'b0010000: mem_res = {24'd0, ld_byte};
            7'b0001000: mem_res = {{16{ld_half[15]}}, ld_half};
            7'b0000100: mem_res = {16'd0, ld_half};
            default:    mem_res = ld_data;
        endcase
    end

    assign final_result = ms_bus.res_from_mem ? mem_res : ms_bus.result;

`ifdef MS_LOAD_FWD_EN
    assign load_pending = ms_valid & ms_bus.res_from_mem & !ms_ready_go;
`else
    assign load_pending = ms_valid & ms_bus.res_from_mem;
`endif

    assign ms_to_ws_bus  = {ms_bus.ex_info, ms_bus.gr_we, ms_bus.dest, final_result, ms_bus.pc};
    assign ms_forward    = {load_pending, final_result, ms_bus.dest, ms_bus.gr_we, ms_valid};
    assign ms_ex         = ms_valid & ms_bus.ex_info[80];
    assign ms_ertn_flush = ms_valid & ms_bus.ex_info[88];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ms_valid   <= 1'b0;
            ms_mem_req <= 1'b0;
            state      <= S_IDLE;
            cancel_cnt <= 2'd0;
            data_buf   <= 32'd0;
            ms_bus     <= '0;
        end else begin
            cancel_cnt <= cnt_next;
            if (flush) begin
                ms_valid   <= 1'b0;
                ms_mem_req <= 1'b0;
                state      <= S_IDLE;
                data_buf   <= 32'd0;
            end else if (ms_allowin) begin
                ms_valid <= es_to_ms_valid;
                data_buf <= 32'd0;
                if (es_to_ms_valid) begin
                    ms_bus     <= es_bus_t'(es_to_ms_bus);
                    ms_mem_req <= es_mem_req;
                    state      <= es_mem_req ? S_WAIT : S_IDLE;
                end else begin
                    ms_mem_req <= 1'b0;
                    state      <= S_IDLE;
                end
            end else if (ms_valid && state == S_WAIT && data_ok_acc) begin
                // WB stalled: park the response until the instruction can leave.
                state    <= S_DONE;
                data_buf <= data_sram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: vector table through a scoreboard plus flush/stall/reset sequences.
module tb_mem_stage;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         ws_allowin = 1'b1;
    logic         ms_allowin;
    logic         es_to_ms_valid = 1'b0;
    logic [169:0] es_to_ms_bus = '0;
    logic         es_mem_req = 1'b0;
    logic         data_sram_data_ok = 1'b0;
    logic [31:0]  data_sram_rdata = '0;
    logic         final_ex = 1'b0;
    logic         back_ertn_flush = 1'b0;
    logic         ms_to_ws_valid;
    logic [159:0] ms_to_ws_bus;
    logic [39:0]  ms_forward;
    logic         ms_ex;
    logic         ms_ertn_flush;

`ifdef MS_LOAD_FWD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    localparam logic [6:0] OP_LW  = 7'b1000000;
    localparam logic [6:0] OP_LB  = 7'b0100000;
    localparam logic [6:0] OP_LBU = 7'b0010000;
    localparam logic [6:0] OP_LH  = 7'b0001000;
    localparam logic [6:0] OP_LHU = 7'b0000100;
    localparam logic [6:0] OP_SB  = 7'b0000010;
    localparam logic [6:0] OP_NONE = 7'b0000000;

    mem_stage dut (
        .clk               (clk),
        .resetn            (resetn),
        .ws_allowin        (ws_allowin),
        .ms_allowin        (ms_allowin),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_to_ms_bus      (es_to_ms_bus),
        .es_mem_req        (es_mem_req),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .final_ex          (final_ex),
        .back_ertn_flush   (back_ertn_flush),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .ms_forward        (ms_forward),
        .ms_ex             (ms_ex),
        .ms_ertn_flush     (ms_ertn_flush)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mem;
        logic [6:0]  ops;
        logic        rfm;
        logic [1:0]  addr;
        logic [31:0] result;
        logic [31:0] rdata;
        logic [31:0] exp;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    logic [159:0] sb_q [$];
    logic [159:0] sb_exp;
    int total = 0;
    int bad = 0;

    function automatic void check(string name, logic [159:0] act, logic [159:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endfunction

    function automatic logic [169:0] mk_bus(logic [89:0] hi, logic [1:0] addr, logic [6:0] ops,
                                            logic rfm, logic [4:0] dest, logic [31:0] res, logic [31:0] pc);
        return {hi, addr, ops, rfm, 1'b1, dest, res, pc};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction for a cycle; optionally record what WB must eventually see.
    task automatic enter(input logic [89:0] hi, input logic [1:0] addr, input logic [6:0] ops,
                         input logic rfm, input logic mem, input logic [4:0] dest,
                         input logic [31:0] res, input logic [31:0] pc,
                         input logic push, input logic [31:0] exp_res);
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk_bus(hi, addr, ops, rfm, dest, res, pc);
        es_mem_req     = mem;
        if (push) sb_q.push_back({hi, 1'b1, dest, exp_res, pc});
        tick();
        es_to_ms_valid = 1'b0;
        es_mem_req     = 1'b0;
    endtask

    always @(negedge clk) begin
        if (resetn && ms_to_ws_valid && ws_allowin) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_extra: got %h want no output", ms_to_ws_bus);
            end else begin
                sb_exp = sb_q.pop_front();
                check("sb_out", ms_to_ws_bus, sb_exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b1, OP_LB,   1'b1, 2'b11, 32'h0,         32'h80AA_5566, 32'hFFFF_FF80};
        vecs[1]  = '{1'b1, OP_LBU,  1'b1, 2'b11, 32'h0,         32'h80AA_5566, 32'h0000_0080};
        vecs[2]  = '{1'b1, OP_LB,   1'b1, 2'b00, 32'h0,         32'h80AA_5566, 32'h0000_0066};
        vecs[3]  = '{1'b1, OP_LB,   1'b1, 2'b10, 32'h0,         32'h80AA_5566, 32'hFFFF_FFAA};
        vecs[4]  = '{1'b1, OP_LBU,  1'b1, 2'b01, 32'h0,         32'h80AA_5566, 32'h0000_0055};
        vecs[5]  = '{1'b1, OP_LH,   1'b1, 2'b10, 32'h0,         32'h8001_1234, 32'hFFFF_8001};
        vecs[6]  = '{1'b1, OP_LHU,  1'b1, 2'b00, 32'h0,         32'h8001_1234, 32'h0000_1234};
        vecs[7]  = '{1'b1, OP_LH,   1'b1, 2'b00, 32'h0,         32'h0000_F00D, 32'hFFFF_F00D};
        vecs[8]  = '{1'b1, OP_LW,   1'b1, 2'b00, 32'h0,         32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[9]  = '{1'b0, OP_NONE, 1'b0, 2'b00, 32'h0000_1234, 32'h0,         32'h0000_1234};
        vecs[10] = '{1'b1, OP_SB,   1'b0, 2'b01, 32'hCAFE_0000, 32'h1111_1111, 32'hCAFE_0000};

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_allowin", 160'(ms_allowin), 160'(1));
        check("rst_to_ws_valid", 160'(ms_to_ws_valid), 160'(0));
        check("rst_to_ws_bus", ms_to_ws_bus, 160'(0));
        check("rst_forward", 160'(ms_forward), 160'(0));
        check("rst_ex", 160'({ms_ex, ms_ertn_flush}), 160'(0));
        tick();
        resetn = 1'b1;
        tick();

        for (int i = 0; i < NV; i++) begin
            enter(90'h0, vecs[i].addr, vecs[i].ops, vecs[i].rfm, vecs[i].mem, 5'(i + 1),
                  vecs[i].result, 32'h1C00_0000 + 32'(i * 4), 1'b1, vecs[i].exp);
            if (vecs[i].mem) begin
                @(negedge clk);
                check("wait_vld", 160'(ms_to_ws_valid), 160'(0));
                if (vecs[i].rfm) check("wait_pend", 160'(ms_forward[39]), 160'(1));
                tick();
                data_sram_data_ok = 1'b1;
                data_sram_rdata   = vecs[i].rdata;
                @(negedge clk);
                check("done_vld", 160'(ms_to_ws_valid), 160'(1));
                check("done_res", 160'(ms_forward[38:7]), 160'(vecs[i].exp));
                if (vecs[i].rfm) check("done_pend", 160'(ms_forward[39]), 160'(!FWD_EN));
                tick();
                data_sram_data_ok = 1'b0;
            end else begin
                @(negedge clk);
                check("alu_vld", 160'(ms_to_ws_valid), 160'(1));
                check("alu_res", 160'(ms_forward[38:7]), 160'(vecs[i].exp));
                tick();
            end
        end

        // ld_hu held by WB for three cycles: the buffered half survives garbage on rdata.
        enter(90'h0, 2'b10, OP_LHU, 1'b1, 1'b1, 5'd3, 32'h0, 32'h1C00_0100, 1'b1, 32'h0000_8001);
        ws_allowin        = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h8001_1234;
        @(negedge clk);
        check("buf_take_vld", 160'(ms_to_ws_valid), 160'(1));
        tick();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'hFFFF_FFFF;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("buf_hold_res", 160'(ms_forward[38:7]), 160'(32'h0000_8001));
            check("buf_hold_allowin", 160'(ms_allowin), 160'(0));
            tick();
        end
        ws_allowin = 1'b1;
        tick();

        // Flush in WAIT with a new request in flight: two stale responses must be dropped.
        enter(90'h0, 2'b00, OP_LW, 1'b1, 1'b1, 5'd4, 32'h0, 32'h1C00_0200, 1'b0, 32'h0);
        final_ex       = 1'b1;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk_bus(90'h0, 2'b00, OP_LW, 1'b1, 5'd5, 32'h0, 32'h1C00_0204);
        es_mem_req     = 1'b1;
        @(negedge clk);
        check("flush_vld", 160'(ms_to_ws_valid), 160'(0));
        tick();
        final_ex       = 1'b0;
        es_to_ms_valid = 1'b0;
        es_mem_req     = 1'b0;
        @(negedge clk);
        check("cnt_two", 160'(dut.cancel_cnt), 160'(2));
        check("flush_valid", 160'(ms_forward[0]), 160'(0));
        tick();
        enter(90'h0, 2'b00, OP_LW, 1'b1, 1'b1, 5'd6, 32'h0, 32'h1C00_0300, 1'b1, 32'h600D_F00D);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hBAD0_0001;
        @(negedge clk);
        check("drop1_vld", 160'(ms_to_ws_valid), 160'(0));
        tick();
        data_sram_rdata = 32'hBAD0_0002;
        @(negedge clk);
        check("drop2_vld", 160'(ms_to_ws_valid), 160'(0));
        tick();
        data_sram_rdata = 32'h600D_F00D;
        @(negedge clk);
        check("keep_vld", 160'(ms_to_ws_valid), 160'(1));
        tick();
        data_sram_data_ok = 1'b0;

        // Flush coinciding with the awaited data_ok consumes it; nothing left to cancel.
        enter(90'h0, 2'b00, OP_LW, 1'b1, 1'b1, 5'd7, 32'h0, 32'h1C00_0400, 1'b0, 32'h0);
        final_ex          = 1'b1;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h1234_5678;
        @(negedge clk);
        check("flushok_vld", 160'(ms_to_ws_valid), 160'(0));
        tick();
        final_ex          = 1'b0;
        data_sram_data_ok = 1'b0;
        @(negedge clk);
        check("flushok_cnt", 160'(dut.cancel_cnt), 160'(0));
        check("flushok_valid", 160'(ms_forward[0]), 160'(0));
        tick();

        // Exception and ertn markers ride along with a plain ALU op.
        enter((90'd1 << 80) | (90'd1 << 88), 2'b00, OP_NONE, 1'b0, 1'b0, 5'd8, 32'h0000_0ABC,
              32'h1C00_0500, 1'b1, 32'h0000_0ABC);
        @(negedge clk);
        check("ex_flag", 160'(ms_ex), 160'(1));
        check("ertn_flag", 160'(ms_ertn_flush), 160'(1));
        tick();

        // ertn flush kills a WB-stalled instruction.
        ws_allowin = 1'b0;
        enter(90'h0, 2'b00, OP_NONE, 1'b0, 1'b0, 5'd9, 32'h0000_0777, 32'h1C00_0600, 1'b0, 32'h0);
        back_ertn_flush = 1'b1;
        @(negedge clk);
        check("ertn_stall_allowin", 160'(ms_allowin), 160'(0));
        tick();
        back_ertn_flush = 1'b0;
        ws_allowin      = 1'b1;
        @(negedge clk);
        check("ertn_valid", 160'(ms_forward[0]), 160'(0));
        check("ertn_to_ws", 160'(ms_to_ws_valid), 160'(0));
        tick();

        // Async reset in the middle of WAIT.
        enter(90'h0, 2'b00, OP_LW, 1'b1, 1'b1, 5'd10, 32'h0, 32'h1C00_0700, 1'b0, 32'h0);
        #1;
        resetn = 1'b0;
        #1;
        check("arst_valid", 160'(ms_forward[0]), 160'(0));
        check("arst_allowin", 160'(ms_allowin), 160'(1));
        check("arst_cnt", 160'(dut.cancel_cnt), 160'(0));
        tick();
        resetn = 1'b1;
        tick();

        check("sb_empty", 160'(sb_q.size()), 160'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
